// File: rtl/jk_excite_seq_if.sv
// Bus bundle between a host/JK-flop side and the jk_excite_seq sequencer.
interface jk_excite_seq_if #(
   parameter int unsigned LEN   = 8,
   parameter int unsigned CNT_W = 8
);
   logic             load;
   logic [LEN-1:0]   pattern;
   logic             start;
   logic             q_fb;
   logic             j;
   logic             k;
   logic             busy;
   logic             done;
   logic             mismatch;
   logic [CNT_W-1:0] err_cnt;

   // Host and flop side: issues commands, returns q feedback.
   modport master (
      output load, pattern, start, q_fb,
      input  j, k, busy, done, mismatch, err_cnt
   );

   // Sequencer side.
   modport slave (
      input  load, pattern, start, q_fb,
      output j, k, busy, done, mismatch, err_cnt
   );
endinterface

// File: rtl/jk_excite_seq.sv
// Drives J/K of an external JK flop so q follows a programmed pattern, checking q per bit.
// Optional JKSEQ_TOGGLE_EN: state-changing steps drive toggle (11) instead of set/reset codes.
module jk_excite_seq #(
   parameter int unsigned LEN   = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   jk_excite_seq_if.slave bus
);
   localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

   typedef enum logic [2:0] {IDLE, DRIVE, APPLY, CHECK, DONE} state_t;

   state_t           state, state_nxt;
   logic [LEN-1:0]   pat, pat_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             j_q, k_q, j_nxt, k_nxt;
   logic             busy_q, done_q, busy_nxt, done_nxt;
   logic             mis_q, mis_nxt;
   logic [CNT_W-1:0] err_q, err_nxt;
   logic             tgt;

   assign tgt = pat[idx];

   // Next-state, excitation and checking logic.
   always_comb begin
      state_nxt = state;
      pat_nxt   = pat;
      idx_nxt   = idx;
      j_nxt     = 1'b0;
      k_nxt     = 1'b0;
      mis_nxt   = 1'b0;
      err_nxt   = err_q;
      case (state)
         IDLE, DONE: begin
            if (bus.load) pat_nxt = bus.pattern;
            if (bus.start) begin
               idx_nxt   = '0;
               err_nxt   = '0;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
`ifdef JKSEQ_TOGGLE_EN
            j_nxt = tgt ^ bus.q_fb;
            k_nxt = tgt ^ bus.q_fb;
`else
            j_nxt = tgt & ~bus.q_fb;
            k_nxt = ~tgt & bus.q_fb;
`endif
            state_nxt = APPLY;
         end
         APPLY: state_nxt = CHECK;
         CHECK: begin
            if (bus.q_fb != tgt) begin
               mis_nxt = 1'b1;
               if (err_q != '1) err_nxt = err_q + CNT_W'(1);
            end
            if (idx == IDX_W'(LEN - 1)) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx + IDX_W'(1);
               state_nxt = DRIVE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == DRIVE) || (state_nxt == APPLY) || (state_nxt == CHECK);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         pat    <= '0;
         idx    <= '0;
         j_q    <= 1'b0;
         k_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         err_q  <= '0;
      end else begin
         state  <= state_nxt;
         pat    <= pat_nxt;
         idx    <= idx_nxt;
         j_q    <= j_nxt;
         k_q    <= k_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         mis_q  <= mis_nxt;
         err_q  <= err_nxt;
      end
   end

   assign bus.j        = j_q;
   assign bus.k        = k_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.mismatch = mis_q;
   assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_jk_excite_seq.sv
// Self-checking bench for jk_excite_seq with behavioural JK flop models (ideal or stuck-at-0).
module tb_jk_excite_seq;
   localparam int unsigned LEN = 8;

   logic clk = 1'b0;
   logic reset;
   logic stuck;
   logic fq, fq2;
   int   ncmp  = 0;
   int   nfail = 0;
   logic [LEN-1:0] model_pat;
   logic           model_q;

   always #5 clk = ~clk;

   jk_excite_seq_if #(.LEN(LEN), .CNT_W(8)) bus ();
   jk_excite_seq_if #(.LEN(LEN), .CNT_W(2)) bus2 ();

   jk_excite_seq #(.LEN(LEN), .CNT_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
   jk_excite_seq #(.LEN(LEN), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   assign bus2.load    = bus.load;
   assign bus2.pattern = bus.pattern;
   assign bus2.start   = bus.start;

   // Edge-triggered JK flops; stuck forces the visible q to 0.
   always_ff @(posedge clk) begin
      if (reset) fq <= 1'b0;
      else case ({bus.j, bus.k})
         2'b10:   fq <= 1'b1;
         2'b01:   fq <= 1'b0;
         2'b11:   fq <= ~fq;
         default: fq <= fq;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) fq2 <= 1'b0;
      else case ({bus2.j, bus2.k})
         2'b10:   fq2 <= 1'b1;
         2'b01:   fq2 <= 1'b0;
         2'b11:   fq2 <= ~fq2;
         default: fq2 <= fq2;
      endcase
   end
   assign bus.q_fb  = stuck ? 1'b0 : fq;
   assign bus2.q_fb = stuck ? 1'b0 : fq2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Excitation needed to move a flop from q to t.
   function automatic logic [1:0] exp_jk(input logic q, input logic t);
      if (q == t) return 2'b00;
`ifdef JKSEQ_TOGGLE_EN
      return 2'b11;
`else
      return t ? 2'b10 : 2'b01;
`endif
   endfunction

   // One full run; inject>0 pulses load+start (inverted pattern) at that cycle of the run.
   task automatic run(input logic do_load, input logic [LEN-1:0] p, input int inject);
      int   errs;
      int   cyc;
      logic q;
      logic t;
      if (do_load) model_pat = p;
      bus.load    = do_load;
      bus.pattern = p;
      bus.start   = 1'b1;
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      chk("done_after_start", 32'(bus.done), 32'd0);
      chk("errcnt_cleared", 32'(bus.err_cnt), 32'd0);
      errs = 0;
      cyc  = 1;
      q    = model_q;
      for (int i = 0; i < int'(LEN); i++) begin
         t = model_pat[i];
         for (int ph = 0; ph < 3; ph++) begin
            if (cyc == inject) begin
               bus.load    = 1'b1;
               bus.start   = 1'b1;
               bus.pattern = ~model_pat;
            end else begin
               bus.load  = 1'b0;
               bus.start = 1'b0;
            end
            tick();
            cyc++;
            if (ph == 0) begin
               chk("jk_apply", 32'({bus.j, bus.k}), 32'(exp_jk(q, t)));
               chk("mismatch_low", 32'(bus.mismatch), 32'd0);
            end else if (ph == 1) begin
               chk("jk_zero", 32'({bus.j, bus.k}), 32'd0);
               q = stuck ? 1'b0 : t;
            end else begin
               chk("mismatch", 32'(bus.mismatch), 32'(q != t));
               if (q != t) errs++;
               if (i < int'(LEN) - 1) chk("done_early", 32'(bus.done), 32'd0);
            end
         end
      end
      bus.load  = 1'b0;
      bus.start = 1'b0;
      chk("done", 32'(bus.done), 32'd1);
      chk("busy_end", 32'(bus.busy), 32'd0);
      chk("err_cnt", 32'(bus.err_cnt), 32'((errs > 255) ? 255 : errs));
      chk("done_w2", 32'(bus2.done), 32'd1);
      chk("err_cnt_w2", 32'(bus2.err_cnt), 32'((errs > 3) ? 3 : errs));
      tick();
      chk("mismatch_pulse_end", 32'(bus.mismatch), 32'd0);
      chk("err_cnt_hold", 32'(bus.err_cnt), 32'((errs > 255) ? 255 : errs));
      chk("done_hold", 32'(bus.done), 32'd1);
      model_q = q;
   endtask

   initial begin
      stuck       = 1'b0;
      reset       = 1'b1;
      bus.load    = 1'b0;
      bus.start   = 1'b0;
      bus.pattern = '0;
      model_pat   = '0;
      model_q     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_jk", 32'({bus.j, bus.k}), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_mismatch", 32'(bus.mismatch), 32'd0);
      chk("rst_err", 32'(bus.err_cnt), 32'd0);

      // Directed pattern from a flop starting at 0.
      run(1'b1, 8'b1010_0110, -1);
      // Load/start while busy must be ignored.
      run(1'b1, LEN'($urandom), 5);
      // No load: previous pattern retained.
      run(1'b0, LEN'($urandom), -1);
      for (int n = 0; n < 6; n++) run(1'b1, LEN'($urandom), int'($urandom_range(1, 23)));

      // Stuck flop: mismatches and counter saturation.
      stuck   = 1'b1;
      model_q = 1'b0;
      run(1'b1, 8'hFF, -1);
      run(1'b1, LEN'($urandom), -1);

      // Reset during the APPLY cycle of bit 1.
      bus.load    = 1'b1;
      bus.pattern = 8'hFF;
      bus.start   = 1'b1;
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      repeat (4) tick();
      chk("pre_reset_j", 32'(bus.j), 32'd1);
      chk("pre_reset_err", 32'(bus.err_cnt), 32'd1);
      reset = 1'b1;
      tick();
      chk("midrst_jk", 32'({bus.j, bus.k}), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_err", 32'(bus.err_cnt), 32'd0);
      chk("midrst_err_w2", 32'(bus2.err_cnt), 32'd0);
      tick();
      reset     = 1'b0;
      stuck     = 1'b0;
      model_q   = 1'b0;
      model_pat = '0;
      tick();
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      // Pattern register was cleared by reset.
      run(1'b0, LEN'($urandom), -1);
      run(1'b1, LEN'($urandom), -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
